// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result stage: NZCV flag capture and 2-entry valid/ready buffer
//
// Optional feature macro: STICKY_FLAGS_EN (adds sticky_cv / clr_sticky)
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  upstream handshake; in_ready is registered state only
//   in_result          ALU result word (N bits)
//   in_carry           ALU carry-out
//   in_overflow        ALU signed overflow
//   out_valid/out_ready downstream handshake for the head entry
//   out_result         head-entry result, 0 when empty
//   out_flags          head-entry flags {N,Z,C,V}, 0 when empty
//   accepted_count     accepted results, wraps mod 2^CNT_W
//   sticky_cv          {C,V} OR-accumulated over popped entries (STICKY_FLAGS_EN)
//   clr_sticky         synchronous clear of sticky_cv, wins over a same-cycle pop (STICKY_FLAGS_EN)

module alu_result_stage #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_result,
    input  logic             in_carry,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] accepted_count
`ifdef STICKY_FLAGS_EN
    ,
    output logic [1:0]       sticky_cv,
    input  logic             clr_sticky
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    // Low while in reset and for the first edge after release, so in_ready
    // is forced low during reset and comes up from a flop afterwards.
    logic           live;

    logic [N-1:0]   head_result;
    logic [3:0]     head_flags;
    logic [N-1:0]   tail_result;
    logic [3:0]     tail_flags;

    logic           push;
    logic           pop;
    logic [3:0]     in_flags;

    // Flags are frozen with the entry at push time.
    assign in_flags = {in_result[N-1], (in_result == '0), in_carry, in_overflow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_EMPTY: begin
                in_ready = live;
            end
            ST_ONE: begin
                in_ready  = live;
                out_valid = 1'b1;
            end
            ST_FULL: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
        push = in_valid & in_ready;
        pop  = out_valid & out_ready;
        case (state)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_nxt = ST_FULL;
                else if (pop && !push) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Head register always drives the outputs; it is zeroed whenever the
    // buffer drains so the outputs read 0 while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_result <= '0;
            head_flags  <= '0;
            tail_result <= '0;
            tail_flags  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        head_result <= in_result;
                        head_flags  <= in_flags;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_result <= in_result;
                        head_flags  <= in_flags;
                    end else if (push) begin
                        tail_result <= in_result;
                        tail_flags  <= in_flags;
                    end else if (pop) begin
                        head_result <= '0;
                        head_flags  <= '0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head_result <= tail_result;
                        head_flags  <= tail_flags;
                        tail_result <= '0;
                        tail_flags  <= '0;
                    end
                end
                default: begin
                    head_result <= '0;
                    head_flags  <= '0;
                end
            endcase
        end
    end

    assign out_result = head_result;
    assign out_flags  = head_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accepted_count <= '0;
        end else if (push) begin
            accepted_count <= accepted_count + CNT_W'(1);
        end
    end

`ifdef STICKY_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_cv <= 2'b00;
        end else if (clr_sticky) begin
            sticky_cv <= 2'b00;
        end else if (pop) begin
            sticky_cv <= sticky_cv | head_flags[1:0];
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage

module tb_alu_result_stage;

    localparam int N     = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_result;
    logic             in_carry;
    logic             in_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_result;
    logic [3:0]       out_flags;
    logic [CNT_W-1:0] accepted_count;
`ifdef STICKY_FLAGS_EN
    logic [1:0]       sticky_cv;
    logic             clr_sticky;
    logic [1:0]       m_sticky;
`endif

    always #5 clk = ~clk;

    alu_result_stage #(.N(N), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_result      (in_result),
        .in_carry       (in_carry),
        .in_overflow    (in_overflow),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_flags      (out_flags),
        .accepted_count (accepted_count)
`ifdef STICKY_FLAGS_EN
        ,
        .sticky_cv      (sticky_cv),
        .clr_sticky     (clr_sticky)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: FIFO of {result, flags} entries, capacity 2.
    logic [7:0]       m_q[$];
    logic [CNT_W-1:0] m_count;

    typedef struct {
        logic       iv;
        logic [3:0] r;
        logic       c;
        logic       v;
        logic       ordy;
        logic       e_ov;
        logic       e_ir;
        logic [3:0] e_res;
        logic [3:0] e_fl;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] flags_of(input logic [3:0] r, input logic c, input logic v);
        return {r[3], (r == 4'b0000), c, v};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_count = '0;
`ifdef STICKY_FLAGS_EN
        m_sticky = 2'b00;
`endif
    endtask

    // Called at posedge+1: drive inputs, compare against the model mid-cycle,
    // advance the model, return at the next posedge+1.
    task automatic cycle(input logic iv, input logic [3:0] r, input logic c, input logic v,
                         input logic ordy);
        logic [7:0] head;
        logic       m_push;
        logic       m_pop;
        in_valid    = iv;
        in_result   = r;
        in_carry    = c;
        in_overflow = v;
        out_ready   = ordy;
        #3;
        head = (m_q.size() != 0) ? m_q[0] : 8'h00;
        check("mdl_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        check("mdl_in_ready", 32'(in_ready), 32'(m_q.size() < 2));
        check("mdl_out_result", 32'(out_result), 32'(head[7:4]));
        check("mdl_out_flags", 32'(out_flags), 32'(head[3:0]));
        check("mdl_count", 32'(accepted_count), 32'(m_count));
`ifdef STICKY_FLAGS_EN
        check("mdl_sticky", 32'(sticky_cv), 32'(m_sticky));
`endif
        m_push = iv && (m_q.size() < 2);
        m_pop  = (m_q.size() != 0) && ordy;
`ifdef STICKY_FLAGS_EN
        if (clr_sticky) m_sticky = 2'b00;
        else if (m_pop) m_sticky = m_sticky | head[1:0];
`endif
        if (m_pop) void'(m_q.pop_front());
        if (m_push) begin
            m_q.push_back({r, flags_of(r, c, v)});
            m_count++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            iv    r        c     v     ordy  e_ov  e_ir  e_res    e_fl
        vecs[0] = '{1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1110, 4'b1000};
        vecs[1] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000};
        vecs[2] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0100};
        vecs[3] = '{1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100};
        vecs[4] = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100};
        vecs[5] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0111, 4'b0000};
        vecs[6] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000};
        vecs[7] = '{1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0011, 4'b0010};
        vecs[8] = '{1'b1, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0101, 4'b0001};
        vecs[9] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_result   = 4'b0000;
        in_carry    = 1'b0;
        in_overflow = 1'b0;
        out_ready   = 1'b0;
`ifdef STICKY_FLAGS_EN
        clr_sticky  = 1'b0;
`endif
        model_reset();

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_count", 32'(accepted_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Directed vector table: expected state after each edge.
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].iv, vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].ordy);
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            check($sformatf("vec%0d_out_result", i), 32'(out_result), 32'(vecs[i].e_res));
            check($sformatf("vec%0d_out_flags", i), 32'(out_flags), 32'(vecs[i].e_fl));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
`ifdef STICKY_FLAGS_EN
            clr_sticky = ($urandom_range(0, 7) == 0);
`endif
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end
`ifdef STICKY_FLAGS_EN
        clr_sticky = 1'b0;
`endif

        // Asynchronous reset with a full buffer.
        cycle(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_count", 32'(accepted_count), 32'd0);
        check("midrst_out_result", 32'(out_result), 32'd0);
        check("midrst_out_flags", 32'(out_flags), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rerelease_in_ready", 32'(in_ready), 32'd1);
        check("rerelease_out_valid", 32'(out_valid), 32'd0);

        // Counter wrap: 256 back-to-back pushes with the consumer always ready.
        for (int i = 0; i < 255; i++) cycle(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b1);
        check("count_255", 32'(accepted_count), 32'd255);
        cycle(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
        check("count_wrap", 32'(accepted_count), 32'd0);
        cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("drained_out_valid", 32'(out_valid), 32'd0);

`ifdef STICKY_FLAGS_EN
        clr_sticky = 1'b1;
        cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        clr_sticky = 1'b0;
        check("sticky_clr0", 32'(sticky_cv), 32'd0);
        cycle(1'b1, 4'b1001, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'b0100, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("sticky_c", 32'(sticky_cv), 32'd2);
        cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("sticky_cv", 32'(sticky_cv), 32'd3);
        cycle(1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        clr_sticky = 1'b1;
        cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        clr_sticky = 1'b0;
        check("sticky_clr_pop", 32'(sticky_cv), 32'd0);
        check("sticky_clr_popped", 32'(out_valid), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
